id_ex_pipe: RTL and testbench

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/id_ex_pipe.sv | 119 +++++++++++
 tb/tb_id_ex_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with load-use hazard detection and flush
// Optional hazard statistics counters are enabled by defining HAZARD_STATS_EN.
module id_ex_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [1:0]       id_ALUOp_i,
  input  logic             id_ALUSrc_i,
  input  logic             id_branch_i,
  input  logic             id_MemRead_i,
  input  logic             id_MemWrite_i,
  input  logic             id_RegWrite_i,
  input  logic             id_MemtoReg_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic [9:0]       id_funct_i,
  output logic [1:0]       ex_ALUOp_o,
  output logic             ex_ALUSrc_o,
  output logic             ex_branch_o,
  output logic             ex_MemRead_o,
  output logic             ex_MemWrite_o,
  output logic             ex_RegWrite_o,
  output logic             ex_MemtoReg_o,
  output logic [XLEN-1:0]  ex_rs1_data_o,
  output logic [XLEN-1:0]  ex_rs2_data_o,
  output logic [XLEN-1:0]  ex_imm_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic [4:0]       ex_rs1_o,
  output logic [4:0]       ex_rs2_o,
  output logic [4:0]       ex_rd_o,
  output logic [9:0]       ex_funct_o,
  output logic             ex_valid_o,
  output logic             stall_o,
  output logic             noop_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic hazard;
  logic bubble;

  // A load in EX whose destination feeds the instruction in ID cannot be forwarded in time.
  assign hazard = ex_valid_o & ex_MemRead_o & (ex_rd_o != 5'd0) &
                  ((ex_rd_o == id_rs1_i) | (ex_rd_o == id_rs2_i));
  assign stall_o = hazard & ~flush_i & ~rst_i;
  assign noop_o  = stall_o;
  assign bubble  = flush_i | hazard;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || bubble) begin
      ex_ALUOp_o    <= 2'b00;
      ex_ALUSrc_o   <= 1'b0;
      ex_branch_o   <= 1'b0;
      ex_MemRead_o  <= 1'b0;
      ex_MemWrite_o <= 1'b0;
      ex_RegWrite_o <= 1'b0;
      ex_MemtoReg_o <= 1'b0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_pc_o       <= '0;
      ex_rs1_o      <= 5'd0;
      ex_rs2_o      <= 5'd0;
      ex_rd_o       <= 5'd0;
      ex_funct_o    <= 10'd0;
      ex_valid_o    <= 1'b0;
    end else begin
      ex_ALUOp_o    <= id_ALUOp_i;
      ex_ALUSrc_o   <= id_ALUSrc_i;
      ex_branch_o   <= id_branch_i;
      ex_MemRead_o  <= id_MemRead_i;
      ex_MemWrite_o <= id_MemWrite_i;
      ex_RegWrite_o <= id_RegWrite_i;
      ex_MemtoReg_o <= id_MemtoReg_i;
      ex_rs1_data_o <= id_rs1_data_i;
      ex_rs2_data_o <= id_rs2_data_i;
      ex_imm_o      <= id_imm_i;
      ex_pc_o       <= id_pc_i;
      ex_rs1_o      <= id_rs1_i;
      ex_rs2_o      <= id_rs2_i;
      ex_rd_o       <= id_rd_i;
      ex_funct_o    <= id_funct_i;
      ex_valid_o    <= 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (flush_i && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - self-checking bench for id_ex_pipe against a transaction-level model
module tb_id_ex_pipe;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [1:0]      alu_op;
    logic            alu_src;
    logic            branch;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [9:0]      funct;
  } instr_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic flush_i;
  instr_t id_drv;
  instr_t ex_obs;

  logic [1:0] ex_ALUOp_o;
  logic ex_ALUSrc_o, ex_branch_o, ex_MemRead_o, ex_MemWrite_o, ex_RegWrite_o, ex_MemtoReg_o;
  logic [XLEN-1:0] ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o;
  logic [4:0] ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [9:0] ex_funct_o;
  logic ex_valid_o, stall_o, noop_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: what EX should hold, and the expected statistics.
  instr_t exp_ex;
  bit     exp_valid;
  int     exp_scnt;
  int     exp_fcnt;

  always #5 clk_i = ~clk_i;

  assign ex_obs = '{ex_ALUOp_o, ex_ALUSrc_o, ex_branch_o, ex_MemRead_o, ex_MemWrite_o,
                    ex_RegWrite_o, ex_MemtoReg_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
                    ex_pc_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct_o};

  id_ex_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .id_ALUOp_i(id_drv.alu_op), .id_ALUSrc_i(id_drv.alu_src), .id_branch_i(id_drv.branch),
    .id_MemRead_i(id_drv.mem_read), .id_MemWrite_i(id_drv.mem_write),
    .id_RegWrite_i(id_drv.reg_write), .id_MemtoReg_i(id_drv.mem_to_reg),
    .id_rs1_data_i(id_drv.rs1_data), .id_rs2_data_i(id_drv.rs2_data),
    .id_imm_i(id_drv.imm), .id_pc_i(id_drv.pc),
    .id_rs1_i(id_drv.rs1), .id_rs2_i(id_drv.rs2), .id_rd_i(id_drv.rd), .id_funct_i(id_drv.funct),
    .ex_ALUOp_o(ex_ALUOp_o), .ex_ALUSrc_o(ex_ALUSrc_o), .ex_branch_o(ex_branch_o),
    .ex_MemRead_o(ex_MemRead_o), .ex_MemWrite_o(ex_MemWrite_o),
    .ex_RegWrite_o(ex_RegWrite_o), .ex_MemtoReg_o(ex_MemtoReg_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_imm_o(ex_imm_o), .ex_pc_o(ex_pc_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_funct_o(ex_funct_o),
    .ex_valid_o(ex_valid_o), .stall_o(stall_o), .noop_o(noop_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Does the instruction in ID read the register a load in EX is about to produce?
  function automatic bit model_load_use(input instr_t id);
    if (!exp_valid || !exp_ex.mem_read || exp_ex.rd == 5'd0) return 1'b0;
    return (id.rs1 == exp_ex.rd) || (id.rs2 == exp_ex.rd);
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.alu_op     = 2'($urandom_range(0, 3));
    t.alu_src    = 1'($urandom_range(0, 1));
    t.branch     = 1'($urandom_range(0, 1));
    t.mem_read   = 1'($urandom_range(0, 1));
    t.mem_write  = 1'($urandom_range(0, 1));
    t.reg_write  = 1'($urandom_range(0, 1));
    t.mem_to_reg = 1'($urandom_range(0, 1));
    t.rs1_data   = $urandom;
    t.rs2_data   = $urandom;
    t.imm        = $urandom;
    t.pc         = $urandom;
    t.rs1        = 5'($urandom_range(0, 3));
    t.rs2        = 5'($urandom_range(0, 3));
    t.rd         = 5'($urandom_range(0, 3));
    t.funct      = 10'($urandom_range(0, 1023));
    return t;
  endfunction

  function automatic instr_t blank_instr();
    instr_t t;
    t = '0;
    return t;
  endfunction

  task automatic model_reset();
    exp_ex    = '0;
    exp_valid = 1'b0;
    exp_scnt  = 0;
    exp_fcnt  = 0;
  endtask

  task automatic check_ex(input string tag);
    chk({tag, ".ex"}, ex_obs, exp_ex);
    chk({tag, ".valid"}, ex_valid_o, exp_valid);
    chk({tag, ".scnt"}, stall_cnt_o, exp_scnt);
    chk({tag, ".fcnt"}, flush_cnt_o, exp_fcnt);
  endtask

  // One pipeline cycle: present ID + flush, check hazard outputs, clock, check EX.
  task automatic step(input string tag, input instr_t id, input bit fl, output bit stalled);
    bit lu;
    id_drv  = id;
    flush_i = fl;
    #1;
    lu      = model_load_use(id);
    stalled = lu && !fl;
    chk({tag, ".stall"}, stall_o, stalled);
    chk({tag, ".noop"}, noop_o, stalled);
    @(posedge clk_i);
    #1;
    if (fl || lu) begin
      exp_ex    = '0;
      exp_valid = 1'b0;
    end else begin
      exp_ex    = id;
      exp_valid = 1'b1;
    end
`ifdef HAZARD_STATS_EN
    if (stalled && exp_scnt < CNT_MAX) exp_scnt++;
    if (fl && exp_fcnt < CNT_MAX) exp_fcnt++;
`endif
    check_ex(tag);
  endtask

  initial begin
    instr_t a, b;
    bit st;
    rst_i   = 1'b1;
    flush_i = 1'b0;
    id_drv  = blank_instr();
    model_reset();
    #3;
    chk("reset.stall", stall_o, 1'b0);
    check_ex("reset");
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Pass-through of an R-type instruction.
    a = rand_instr();
    a.alu_op = 2'b10; a.reg_write = 1'b1; a.mem_read = 1'b0; a.rd = 5'd5; a.rs1_data = 32'h1234;
    step("pass", a, 1'b0, st);

    // Asynchronous reset between edges while EX holds a RegWrite instruction.
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    chk("rst_mid.stall", stall_o, 1'b0);
    check_ex("rst_mid");
    #1;
    rst_i = 1'b0;

    // Load-use: lw x3 then a consumer of x3 in rs2; the consumer is held one cycle.
    a = rand_instr(); a.mem_read = 1'b1; a.rd = 5'd3; a.rs1 = 5'd1; a.rs2 = 5'd1;
    b = rand_instr(); b.mem_read = 1'b0; b.rs1 = 5'd2; b.rs2 = 5'd3;
    step("lu_load", a, 1'b0, st);
    step("lu_stall", b, 1'b0, st);
    chk("lu_stalled", st, 1'b1);
    step("lu_advance", b, 1'b0, st);
    chk("lu_ex_rs2", ex_rs2_o, 5'd3);

    // Back-to-back dependent loads each cost one bubble.
    a.rd = 5'd2;
    b = a; b.rd = 5'd1; b.rs1 = 5'd2;
    step("b2b_l1", a, 1'b0, st);
    step("b2b_l2s", b, 1'b0, st);
    step("b2b_l2", b, 1'b0, st);
    a = rand_instr(); a.rs1 = 5'd1; a.rs2 = 5'd0;
    step("b2b_use_s", a, 1'b0, st);
    step("b2b_use", a, 1'b0, st);

    // Load to x0 never stalls.
    a = rand_instr(); a.mem_read = 1'b1; a.rd = 5'd0;
    b = rand_instr(); b.rs1 = 5'd0; b.rs2 = 5'd0;
    step("x0_load", a, 1'b0, st);
    step("x0_use", b, 1'b0, st);
    chk("x0_valid", ex_valid_o, 1'b1);

    // Load whose rd matches no source of the next instruction.
    a = rand_instr(); a.mem_read = 1'b1; a.rd = 5'd7;
    b = rand_instr(); b.rs1 = 5'd6; b.rs2 = 5'd8;
    step("nomatch_load", a, 1'b0, st);
    step("nomatch_use", b, 1'b0, st);

    // Flush wins over a simultaneous load-use hazard.
    a = rand_instr(); a.mem_read = 1'b1; a.rd = 5'd3;
    b = rand_instr(); b.rs1 = 5'd3;
    step("fl_load", a, 1'b0, st);
    step("fl_hazard", b, 1'b1, st);

    // Twenty consecutive flushes drive the flush counter to saturation.
    for (int i = 0; i < 20; i++) step("fl_run", rand_instr(), 1'b1, st);
`ifdef HAZARD_STATS_EN
    chk("flush_sat", flush_cnt_o, CNT_MAX);
`else
    chk("flush_off", flush_cnt_o, 0);
`endif

    // Random traffic; a stalled instruction is re-presented as the front end would.
    st = 1'b0;
    a = rand_instr();
    for (int i = 0; i < 300; i++) begin
      if (!st) a = rand_instr();
      step("rand", a, ($urandom_range(0, 99) < 15), st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
